multi_dataflow_fir4_kernel: RTL and testbench
=============================================

Name: multi_dataflow_fir4_kernel

Overview:
Synthesizable 4-tap FIR kernel that acts as the responder on the engine's kernel-adapter control handshake. It receives `start` and drives `done`/`idle`/`ready` in ap_ctrl_hs style. It consumes `inStream0` and produces `outStream0` over valid/ready streams, using `coeff_0..3` as taps. It replaces the HLS kernel behind the HWPE engine in integration and regression runs. It counts output handshakes toward `cnt_limit_outStream0` so the engine can report `cnt_outStream0`.

Parameters:
- CNT_LEN, 1024: max vector length; counter width CNT_W = $clog2(CNT_LEN)+1 = 11.
- DATA_W, 32: stream data and coefficient width.
- NB_TAPS, 4: FIR taps; fixed at 4 (matches `coeff_0..3`).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- start_i  in  1  `ctrl_kernel_adapter_t.start`.
- cnt_limit_i  in  CNT_W  number of outputs to produce (`cnt_limit_outStream0`).
- coeff_i  in  NB_TAPS*DATA_W  `{coeff_3,coeff_2,coeff_1,coeff_0}`.
- done_o  out  1  `flags_kernel_adapter_t.done`.
- idle_o  out  1  `flags_kernel_adapter_t.idle`.
- ready_o  out  1  `flags_kernel_adapter_t.ready`.
- cnt_o  out  CNT_W  outputs handshaken so far (`cnt_outStream0`).
- in_data_i  in  DATA_W  inStream0 data.
- in_valid_i  in  1  inStream0 valid.
- in_ready_o  out  1  inStream0 ready.
- out_data_o  out  DATA_W  outStream0 data.
- out_valid_o  out  1  outStream0 valid.
- out_ready_i  in  1  outStream0 ready.

Behaviour:

Reset and clear
- On rst_i or clear_i the state goes to IDLE.
- After reset: idle_o=1; done_o, ready_o, out_valid_o, in_ready_o = 0; cnt_o, out_data_o, taps and all counters = 0.
- Reset or clear mid-RUN aborts the run. No done pulse is issued and any pending output is dropped.

State IDLE
- idle_o=1, in_ready_o=0.
- On start_i=1: latch coefficients; latch lim = min(cnt_limit_i, CNT_LEN).
- Same edge: zero the taps x0..x2, cnt_o and the accepted counter acc.
- ready_o=1 for exactly the next cycle, then go to RUN.

State RUN
- idle_o=0.
- in_ready_o = (acc < lim) && (!out_valid_o || out_ready_i).
- start_i is ignored in RUN.
- Input accept (in_valid_i && in_ready_o), with y = c0*in + c1*x0 + c2*x1 + c3*x2:
  - each product and the sum keep the low DATA_W bits only (modular, sign-agnostic);
  - out_data_o <= y, out_valid_o <= 1 on the next edge;
  - taps shift: x2<=x1, x1<=x0, x0<=in;
  - acc++.
- Latency: 1 cycle from input handshake to out_valid_o.
- Throughput: 1 sample/cycle when out_ready_i=1.
- Output handshake (out_valid_o && out_ready_i):
  - cnt_o++;
  - out_valid_o clears unless a new sample is accepted on the same edge; a simultaneous accept keeps out_valid_o=1 with the new data.
- out_valid_o=1 with out_ready_i=0: out_data_o and out_valid_o hold stable.
- When the handshake makes cnt_o == lim, go to DONE.
- lim=0: go from RUN to DONE on the first RUN cycle; no input is accepted.

State DONE
- done_o=1 for exactly one cycle, in_ready_o=0, then go to IDLE.
- cnt_o holds its final value until the next start.
- start_i during DONE is ignored.

Boundary cases
- Input beyond lim is never accepted.
- Counters never wrap, because lim ≤ CNT_LEN < 2^CNT_W.
- ready_o and done_o are never asserted in the same cycle.

Decomposition:
- Shared package:
  - reuse `ctrl_kernel_adapter_t` and `flags_kernel_adapter_t`;
  - add `FIR_NB_TAPS=4`;
  - add `CNT_W` derived from CNT_LEN;
  - add enum `state_kernel_t` {KRN_IDLE, KRN_RUN, KRN_DONE}.
- Sub-module `multi_dataflow_fir4_datapath`: tap shift register plus MAC, with an enable input. The FSM, counters and output register stay in the top module.

Test Plan:
1. Impulse: coeff {1,2,3,4}, lim=5, input 1,0,0,0,0 with out_ready_i=1 → outputs 1,2,3,4,0; cnt_o=5; ready_o pulses 1 cycle after start; done_o pulses once.
2. Backpressure: same setup with out_ready_i toggling 1,0,0,1,… → out_data_o held stable while stalled; no sample lost or duplicated; in_ready_o=0 while the output register is full and stalled.
3. Zero and clamp: lim=0 → ready pulse, then done pulse within 3 cycles, no in_ready_o, cnt_o=0. cnt_limit_i=2000 → lim=1024; done after 1024 outputs.
4. Wrap: coeff_0=0xFFFFFFFF, others 0, input 2 → out_data_o=0xFFFFFFFE. coeff_0=0x80000000, input 2 → out_data_o=0.
5. Start ignored: assert start_i mid-RUN with new coeff {9,9,9,9} → outputs still use the old coeffs; exactly one done_o.
6. Reset mid-run: assert rst_i after 3 outputs of lim=8 → next cycle idle_o=1, cnt_o=0, out_valid_o=0, no done_o. A fresh start then completes normally with zeroed taps (impulse → 1,2,3,4).

Source files
------------

// File: rtl/multi_dataflow_fir4_kernel_pkg.sv
// Shared types and constants for the 4-tap FIR kernel behind the HWPE engine.
// Provides the kernel-adapter control/flag payloads, the counter width derived
// from the maximum vector length, and the kernel state enumeration.
package multi_dataflow_fir4_kernel_pkg;

    localparam int unsigned CNT_LEN     = 1024;
    localparam int unsigned CNT_W       = $clog2(CNT_LEN) + 1;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned FIR_NB_TAPS = 4;

    // Engine -> kernel control
    typedef struct packed {
        logic start;
    } ctrl_kernel_adapter_t;

    // Kernel -> engine status flags
    typedef struct packed {
        logic done;
        logic idle;
        logic ready;
    } flags_kernel_adapter_t;

    typedef enum logic [1:0] {
        KRN_IDLE = 2'd0,
        KRN_RUN  = 2'd1,
        KRN_DONE = 2'd2
    } state_kernel_t;

endpackage

// File: rtl/multi_dataflow_fir4_kernel_datapath.sv
// Tap shift register and multiply-accumulate for the 4-tap FIR.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (includes soft clear)
//   load_i            latch coefficients and zero the taps (start of a run)
//   en_i              shift the taps with in_data_i (input accepted)
//   coeff_i           {coeff_3, coeff_2, coeff_1, coeff_0}
//   in_data_i         current input sample
//   mac_c_o           combinational c0*in + c1*x0 + c2*x1 + c3*x2 (modular)
module multi_dataflow_fir4_datapath
    import multi_dataflow_fir4_kernel_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_i,
    input  logic                          en_i,
    input  logic [FIR_NB_TAPS*DATA_W-1:0] coeff_i,
    input  logic [DATA_W-1:0]             in_data_i,
    output logic [DATA_W-1:0]             mac_c_o
);

    logic [DATA_W-1:0] coeff_q [FIR_NB_TAPS];
    logic [DATA_W-1:0] taps_q  [FIR_NB_TAPS-1];

    // Coefficient latch and tap delay line
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < FIR_NB_TAPS; k++) coeff_q[k] <= '0;
            for (int k = 0; k < FIR_NB_TAPS-1; k++) taps_q[k] <= '0;
        end else if (load_i) begin
            for (int k = 0; k < FIR_NB_TAPS; k++) coeff_q[k] <= coeff_i[k*DATA_W +: DATA_W];
            for (int k = 0; k < FIR_NB_TAPS-1; k++) taps_q[k] <= '0;
        end else if (en_i) begin
            taps_q[0] <= in_data_i;
            for (int k = 1; k < FIR_NB_TAPS-1; k++) taps_q[k] <= taps_q[k-1];
        end
    end

    // Products and sum are kept to DATA_W bits, so the result is sign-agnostic
    always_comb begin
        mac_c_o = coeff_q[0] * in_data_i;
        for (int k = 1; k < FIR_NB_TAPS; k++) begin
            mac_c_o = mac_c_o + coeff_q[k] * taps_q[k-1];
        end
    end

endmodule

// File: rtl/multi_dataflow_fir4_kernel.sv
// 4-tap FIR kernel responding to the kernel-adapter start/done/idle/ready
// handshake. Consumes inStream0, produces outStream0, and counts output
// handshakes up to the latched limit.
// Ports:
//   clk_i, rst_i, clear_i    clock, synchronous reset and soft clear
//   start_i                  run request (sampled only in IDLE)
//   cnt_limit_i              outputs to produce, clamped to CNT_LEN
//   coeff_i                  {coeff_3, coeff_2, coeff_1, coeff_0}
//   done_o, idle_o, ready_o  status flags
//   cnt_o                    output handshakes so far
//   in_*                     input stream (in_ready_o is combinational)
//   out_*                    output stream (registered data/valid)
module multi_dataflow_fir4_kernel
    import multi_dataflow_fir4_kernel_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [CNT_W-1:0]              cnt_limit_i,
    input  logic [FIR_NB_TAPS*DATA_W-1:0] coeff_i,
    output logic                          done_o,
    output logic                          idle_o,
    output logic                          ready_o,
    output logic [CNT_W-1:0]              cnt_o,
    input  logic [DATA_W-1:0]             in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i
);

    localparam logic [1:0] ST_IDLE = KRN_IDLE;
    localparam logic [1:0] ST_RUN  = KRN_RUN;
    localparam logic [1:0] ST_DONE = KRN_DONE;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      lim_q, lim_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    flags_kernel_adapter_t flags_q, flags_d;

    logic                  rst_c;
    logic                  load_c;
    logic                  in_ready_c;
    logic                  accept_c;
    logic                  out_hs_c;
    logic [DATA_W-1:0]     mac_c;

    assign rst_c = rst_i | clear_i;

    // Output register may be refilled on the same edge it drains
    assign in_ready_c = (state_q == ST_RUN) && (acc_q < lim_q) && (!out_valid_q || out_ready_i);
    assign accept_c   = in_valid_i && in_ready_c;
    assign out_hs_c   = (state_q == ST_RUN) && out_valid_q && out_ready_i;
    assign load_c     = (state_q == ST_IDLE) && start_i;

    multi_dataflow_fir4_datapath u_datapath (
        .clk_i     (clk_i),
        .rst_i     (rst_c),
        .load_i    (load_c),
        .en_i      (accept_c),
        .coeff_i   (coeff_i),
        .in_data_i (in_data_i),
        .mac_c_o   (mac_c)
    );

    // Next-state, counters and output register updates
    always_comb begin
        state_d     = state_q;
        lim_d       = lim_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        flags_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    lim_d   = (cnt_limit_i > CNT_W'(CNT_LEN)) ? CNT_W'(CNT_LEN) : cnt_limit_i;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                    flags_d.ready = 1'b1;
                end
            end
            ST_RUN: begin
                if (lim_q == '0) begin
                    state_d = ST_DONE;
                end
                if (out_hs_c) begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    out_valid_d = 1'b0;
                    if (cnt_q + CNT_W'(1) == lim_q) begin
                        state_d = ST_DONE;
                    end
                end
                if (accept_c) begin
                    out_data_d  = mac_c;
                    out_valid_d = 1'b1;
                    acc_d       = acc_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flags_d.done = (state_d == ST_DONE);
        flags_d.idle = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_c) begin
            state_q     <= ST_IDLE;
            lim_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= '{done: 1'b0, idle: 1'b1, ready: 1'b0};
        end else begin
            state_q     <= state_d;
            lim_q       <= lim_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
        end
    end

    assign done_o      = flags_q.done;
    assign idle_o      = flags_q.idle;
    assign ready_o     = flags_q.ready;
    assign cnt_o       = cnt_q;
    assign in_ready_o  = in_ready_c;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_multi_dataflow_fir4_kernel.sv
// Self-checking bench for multi_dataflow_fir4_kernel: streams are compared
// against a direct convolution model y[n] = sum_k c[k]*x[n-k].
module tb_multi_dataflow_fir4_kernel;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         clear_i = 1'b0;
    logic         start_i = 1'b0;
    logic [10:0]  cnt_limit_i = '0;
    logic [127:0] coeff_i = '0;
    logic         done_o, idle_o, ready_o;
    logic [10:0]  cnt_o;
    logic [31:0]  in_data_i = '0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [31:0]  out_data_o;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] cf  [4];
    logic [31:0] din [$];
    logic [31:0] got [$];
    int          done_cyc;

    always #5 clk_i = ~clk_i;

    multi_dataflow_fir4_kernel dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .cnt_limit_i (cnt_limit_i),
        .coeff_i     (coeff_i),
        .done_o      (done_o),
        .idle_o      (idle_o),
        .ready_o     (ready_o),
        .cnt_o       (cnt_o),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    // Reference: direct 4-tap convolution, zero history, 32-bit modular
    function automatic logic [31:0] model_y(input int n);
        logic [31:0] s;
        logic [31:0] p;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            if (n - k >= 0) begin
                p = cf[k] * din[n-k];
                s = s + p;
            end
        end
        return s;
    endfunction

    // One full start..done run; rmode: 0 ready=1, 1 pattern 1,0,0,1, 2 random
    task automatic run_case(input string name, input int limit_in, input int rmode,
                            input int vmode, input bit start_mid);
        int          exp_lim, idx, outs, ready_cnt, done_cnt, budget, cyc;
        bit          stall_prev, done_seen;
        logic [31:0] stall_data;
        exp_lim = (limit_in > 1024) ? 1024 : limit_in;
        idx = 0; outs = 0; ready_cnt = 0; done_cnt = 0;
        stall_prev = 1'b0; done_seen = 1'b0; stall_data = '0;
        done_cyc = -1;
        got.delete();
        budget = 8 * exp_lim + 40;

        @(negedge clk_i);
        coeff_i     = {cf[3], cf[2], cf[1], cf[0]};
        cnt_limit_i = 11'(limit_in);
        start_i     = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || idle_o !== 1'b0) begin
            failures++;
            $display("FAIL %s start: ready_o=%b idle_o=%b required 1/0", name, ready_o, idle_o);
        end

        for (cyc = 0; cyc < budget && !done_seen; cyc++) begin
            in_valid_i = (idx < din.size()) && (vmode == 0 || $urandom_range(0, 9) < 7);
            in_data_i  = (idx < din.size()) ? din[idx] : $urandom;
            case (rmode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready_i = $urandom_range(0, 1) == 1;
            endcase
            if (start_mid && cyc == 3) begin
                start_i = 1'b1;
                coeff_i = {4{32'd9}};
            end else begin
                start_i = 1'b0;
            end
            #1;
            if (ready_o === 1'b1) ready_cnt++;
            if (done_o === 1'b1) done_cnt++;
            checks++;
            if (ready_o === 1'b1 && done_o === 1'b1) begin
                failures++;
                $display("FAIL %s ready_done_overlap: both 1 at cycle %0d, required not both", name, cyc);
            end
            if (stall_prev) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== stall_data) begin
                    failures++;
                    $display("FAIL %s stall_hold: valid=%b data=%h required 1/%h", name, out_valid_o, out_data_o, stall_data);
                end
            end
            if (out_valid_o === 1'b1 && out_ready_i == 1'b0) begin
                checks++;
                if (in_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s stalled_in_ready: in_ready_o=%b required 0", name, in_ready_o);
                end
            end
            checks++;
            if (in_ready_o === 1'b1 && idx >= exp_lim) begin
                failures++;
                $display("FAIL %s beyond_lim: in_ready_o=1 after %0d accepts, required 0", name, idx);
            end
            if (done_o === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                checks++;
                if (cnt_o !== 11'(exp_lim)) begin
                    failures++;
                    $display("FAIL %s cnt_at_done: cnt_o=%0d required %0d", name, cnt_o, exp_lim);
                end
            end
            if (in_valid_i && in_ready_o === 1'b1) idx++;
            if (out_valid_o === 1'b1 && out_ready_i) begin
                got.push_back(out_data_o);
                checks++;
                if (outs >= exp_lim || out_data_o !== model_y(outs)) begin
                    failures++;
                    $display("FAIL %s out[%0d]: got %h required %h", name, outs, out_data_o,
                             (outs < exp_lim) ? model_y(outs) : 32'hx);
                end
                outs++;
            end
            stall_prev = (out_valid_o === 1'b1) && !out_ready_i;
            stall_data = out_data_o;
            @(posedge clk_i);
            @(negedge clk_i);
        end

        in_valid_i = 1'b0;
        start_i    = 1'b0;
        #1;
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL %s timeout: no done_o within %0d cycles", name, budget);
        end
        checks++;
        if (idle_o !== 1'b1 || done_o !== 1'b0 || cnt_o !== 11'(exp_lim)) begin
            failures++;
            $display("FAIL %s after_done: idle=%b done=%b cnt=%0d required 1/0/%0d", name, idle_o, done_o, cnt_o, exp_lim);
        end
        checks++;
        if (done_cnt != 1 || ready_cnt != 1) begin
            failures++;
            $display("FAIL %s pulses: done=%0d ready=%0d required 1/1", name, done_cnt, ready_cnt);
        end
        checks++;
        if (outs != exp_lim || idx != exp_lim) begin
            failures++;
            $display("FAIL %s counts: outputs=%0d accepts=%0d required %0d", name, outs, idx, exp_lim);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (idle_o !== 1'b1 || done_o !== 1'b0 || ready_o !== 1'b0 || out_valid_o !== 1'b0 ||
            in_ready_o !== 1'b0 || cnt_o !== '0 || out_data_o !== '0) begin
            failures++;
            $display("FAIL reset_state: idle=%b done=%b ready=%b ov=%b ir=%b cnt=%0d data=%h required 1/0/0/0/0/0/0",
                     idle_o, done_o, ready_o, out_valid_o, in_ready_o, cnt_o, out_data_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (idle_o !== 1'b1 || in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: idle=%b in_ready=%b required 1/0", idle_o, in_ready_o);
        end
    endtask

    task automatic set_impulse();
        cf[0] = 32'd1; cf[1] = 32'd2; cf[2] = 32'd3; cf[3] = 32'd4;
        din.delete();
        din.push_back(32'd1);
        repeat (4) din.push_back(32'd0);
    endtask

    task automatic check_impulse_outputs(input string name);
        logic [31:0] exp_v [5];
        exp_v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
        checks++;
        if (got.size() != 5) begin
            failures++;
            $display("FAIL %s impulse_len: got %0d outputs required 5", name, got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== exp_v[i]) begin
                    failures++;
                    $display("FAIL %s impulse[%0d]: got %h required %h", name, i, got[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_impulse();
        set_impulse();
        run_case("impulse", 5, 0, 0, 1'b0);
        check_impulse_outputs("impulse");
    endtask

    task automatic test_backpressure();
        set_impulse();
        run_case("backpressure", 5, 1, 0, 1'b0);
        check_impulse_outputs("backpressure");
    endtask

    task automatic test_zero_and_clamp();
        din.delete();
        cf[0] = 32'd5; cf[1] = 32'd6; cf[2] = 32'd7; cf[3] = 32'd8;
        run_case("zero", 0, 0, 0, 1'b0);
        checks++;
        if (done_cyc < 0 || done_cyc > 2) begin
            failures++;
            $display("FAIL zero done_latency: done at cycle %0d required <= 2", done_cyc);
        end
        for (int k = 0; k < 4; k++) cf[k] = $urandom;
        din.delete();
        for (int i = 0; i < 1024; i++) din.push_back($urandom);
        run_case("clamp", 2000, 0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        cf[0] = 32'hFFFF_FFFF; cf[1] = '0; cf[2] = '0; cf[3] = '0;
        din.delete();
        din.push_back(32'd2);
        run_case("wrap_ff", 1, 0, 0, 1'b0);
        checks++;
        if (got.size() != 1 || got[0] !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL wrap_ff: got size %0d required one output of fffffffe", got.size());
        end
        cf[0] = 32'h8000_0000;
        run_case("wrap_80", 1, 0, 0, 1'b0);
        checks++;
        if (got.size() != 1 || got[0] !== 32'h0) begin
            failures++;
            $display("FAIL wrap_80: got size %0d required one output of 00000000", got.size());
        end
    endtask

    task automatic test_start_ignored();
        cf[0] = 32'd1; cf[1] = 32'd2; cf[2] = 32'd3; cf[3] = 32'd4;
        din.delete();
        for (int i = 0; i < 8; i++) din.push_back($urandom_range(0, 255));
        run_case("start_ignored", 8, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        int  outs, idx;
        bit  done_seen;
        cf[0] = 32'd1; cf[1] = 32'd2; cf[2] = 32'd3; cf[3] = 32'd4;
        din.delete();
        for (int i = 0; i < 8; i++) din.push_back($urandom_range(1, 255));
        outs = 0; idx = 0; done_seen = 1'b0;

        @(negedge clk_i);
        coeff_i     = {cf[3], cf[2], cf[1], cf[0]};
        cnt_limit_i = 11'd8;
        start_i     = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 40 && outs < 3; cyc++) begin
            in_valid_i  = (idx < 8);
            in_data_i   = (idx < 8) ? din[idx] : '0;
            out_ready_i = 1'b1;
            #1;
            if (done_o === 1'b1) done_seen = 1'b1;
            if (in_valid_i && in_ready_o === 1'b1) idx++;
            if (out_valid_o === 1'b1 && out_ready_i) outs++;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (outs != 3) begin
            failures++;
            $display("FAIL reset_mid outputs_before: %0d required 3", outs);
        end
        checks++;
        if (idle_o !== 1'b1 || cnt_o !== '0 || out_valid_o !== 1'b0 || done_o !== 1'b0 || done_seen) begin
            failures++;
            $display("FAIL reset_mid state: idle=%b cnt=%0d ov=%b done=%b seen=%b required 1/0/0/0/0",
                     idle_o, cnt_o, out_valid_o, done_o, done_seen);
        end
        set_impulse();
        run_case("after_reset", 5, 0, 0, 1'b0);
        check_impulse_outputs("after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) cf[k] = $urandom;
            din.delete();
            for (int i = 0; i < 4 + r * 5; i++) din.push_back($urandom);
            run_case("random", 4 + r * 5, 2, 1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_backpressure();
        test_zero_and_clamp();
        test_wrap();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
